// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared micro-PC state codes, sequencing modes, microword layout
// and datapath select encodings for the multicycle ARM control unit.
package arm_mc_pkg;

    localparam int UPC_BITS  = 4;
    localparam int ROM_WORDS = 10;

    localparam logic [UPC_BITS-1:0] S_FETCH  = 4'd0;
    localparam logic [UPC_BITS-1:0] S_DECODE = 4'd1;
    localparam logic [UPC_BITS-1:0] S_MEMADR = 4'd2;
    localparam logic [UPC_BITS-1:0] S_MEMRD  = 4'd3;
    localparam logic [UPC_BITS-1:0] S_MEMWB  = 4'd4;
    localparam logic [UPC_BITS-1:0] S_MEMWR  = 4'd5;
    localparam logic [UPC_BITS-1:0] S_EXECR  = 4'd6;
    localparam logic [UPC_BITS-1:0] S_EXECI  = 4'd7;
    localparam logic [UPC_BITS-1:0] S_ALUWB  = 4'd8;
    localparam logic [UPC_BITS-1:0] S_BRANCH = 4'd9;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    typedef enum logic [1:0] {NEXT, DISP1, DISP2, FETCHRET} seq_t;

    // Raw per-state intents; the top gates the strobes with ready/cond/reset.
    typedef struct packed {
        logic       nextpc;
        logic       branch;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adrsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
    } ctrl_t;

    typedef struct packed {
        seq_t                seq;
        logic [UPC_BITS-1:0] nxt;
        logic                wt;
        ctrl_t               ctrl;
    } uword_t;

endpackage

// File: rtl/arm_micro_rom.sv
// arm_micro_rom: combinational microinstruction ROM, micro-PC -> microword.
//   upc  in   UPC_BITS  micro-PC
//   word out  uword_t   microword; unused addresses return to FETCH with no actions
module arm_micro_rom
    import arm_mc_pkg::*;
(
    input  logic [UPC_BITS-1:0] upc,
    output uword_t              word
);

    always_comb begin
        word = '0;
        case (upc)
            S_FETCH: begin
                word.nxt            = S_DECODE;
                word.wt             = 1'b1;
                word.ctrl.nextpc    = 1'b1;
                word.ctrl.irw       = 1'b1;
                word.ctrl.alusrca   = 1'b1;
                word.ctrl.alusrcb   = SRCB_FOUR;
                word.ctrl.resultsrc = RES_ALURES;
            end
            S_DECODE: begin
                word.seq            = DISP1;
                word.ctrl.alusrca   = 1'b1;
                word.ctrl.alusrcb   = SRCB_FOUR;
                word.ctrl.resultsrc = RES_ALURES;
            end
            S_MEMADR: begin
                word.seq          = DISP2;
                word.ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                word.nxt         = S_MEMWB;
                word.wt          = 1'b1;
                word.ctrl.adrsrc = 1'b1;
            end
            S_MEMWB: begin
                word.seq            = FETCHRET;
                word.ctrl.regw      = 1'b1;
                word.ctrl.resultsrc = RES_DATA;
            end
            S_MEMWR: begin
                word.seq         = FETCHRET;
                word.wt          = 1'b1;
                word.ctrl.memw   = 1'b1;
                word.ctrl.adrsrc = 1'b1;
            end
            S_EXECR: begin
                word.nxt          = S_ALUWB;
                word.ctrl.alusrcb = SRCB_RD2;
                word.ctrl.aluop   = 1'b1;
            end
            S_EXECI: begin
                word.nxt          = S_ALUWB;
                word.ctrl.alusrcb = SRCB_IMM;
                word.ctrl.aluop   = 1'b1;
            end
            S_ALUWB: begin
                word.seq            = FETCHRET;
                word.ctrl.regw      = 1'b1;
                word.ctrl.resultsrc = RES_ALUOUT;
            end
            S_BRANCH: begin
                word.seq            = FETCHRET;
                word.ctrl.branch    = 1'b1;
                word.ctrl.alusrcb   = SRCB_IMM;
                word.ctrl.resultsrc = RES_ALURES;
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/arm_micro_sequencer.sv
// arm_micro_sequencer: microprogrammed control unit for the multicycle ARM datapath.
//   clk, reset (sync, active-low)
//   Op, Funct, Rd   instruction register fields
//   CondEx          condition result, sampled at the end of DECODE
//   mem_ready       memory handshake for wait-bit states
//   PCWrite, MemWrite, RegWrite, IRWrite   gated write strobes
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp   datapath selects from the ROM word
//   upc             current micro-PC
module arm_micro_sequencer
    import arm_mc_pkg::*;
#(
    parameter int UPC_W     = UPC_BITS,
    parameter int ROM_DEPTH = ROM_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic             CondEx,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic [UPC_W-1:0] upc
);

    logic [UPC_BITS-1:0] upc_q, upc_d, disp1, disp2;
    logic                cond_q, cond_d, go;
    uword_t              rom_w, w;
    logic                unused_funct;

    arm_micro_rom u_rom (
        .upc  (upc_q),
        .word (rom_w)
    );

    assign unused_funct = ^Funct[4:1];

    always_comb begin
        w      = (int'(upc_q) < ROM_DEPTH) ? rom_w : '0;
        // A wait-bit state only advances (and fires its ready-gated strobes) once memory is done.
        go     = ~w.wt | mem_ready;
        disp1  = (Op == 2'b01) ? S_MEMADR :
                 (Op == 2'b10) ? S_BRANCH :
                 (Op == 2'b00) ? (Funct[5] ? S_EXECI : S_EXECR) : S_FETCH;
        disp2  = Funct[0] ? S_MEMRD : S_MEMWR;
        upc_d  = !go                 ? upc_q :
                 (w.seq == NEXT)     ? w.nxt :
                 (w.seq == DISP1)    ? disp1 :
                 (w.seq == DISP2)    ? disp2 : S_FETCH;
        cond_d = (upc_q == S_DECODE) ? CondEx : cond_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            upc_q  <= S_FETCH;
            cond_q <= 1'b0;
        end else begin
            upc_q  <= upc_d;
            cond_q <= cond_d;
        end
    end

    assign IRWrite   = reset & w.ctrl.irw & go;
    assign MemWrite  = reset & w.ctrl.memw & cond_q;
    assign RegWrite  = reset & w.ctrl.regw & cond_q;
    assign PCWrite   = reset & ((w.ctrl.nextpc & go) | (w.ctrl.branch & cond_q) |
                                (w.ctrl.regw & cond_q & (Rd == 4'hF)));
    assign AdrSrc    = w.ctrl.adrsrc;
    assign ALUSrcA   = w.ctrl.alusrca;
    assign ALUSrcB   = w.ctrl.alusrcb;
    assign ResultSrc = w.ctrl.resultsrc;
    assign ALUOp     = w.ctrl.aluop;
    assign upc       = UPC_W'(upc_q);

endmodule
